// File: rtl/button_evt_pkg.sv
// Shared types and helpers for the push-button event front end.
package button_evt_pkg;

  // Widest channel index an event record can carry.
  localparam int EVT_CH_W = 8;

  // One press/release event as seen by the register logic.
  typedef struct packed {
    logic [EVT_CH_W-1:0] ch;
    logic                press;
  } btn_evt_t;

  // Clock cycles per debounce sample tick.
  function automatic int tick_cycles(input int freq, input int us);
    return (freq / 1_000_000) * us;
  endfunction

endpackage

// File: rtl/button_db_channel.sv
// One button channel: 2-FF synchronizer plus a stable-sample debouncer.
// The counter only moves on sample ticks and restarts on any agreeing sample.
module button_db_channel #(
  parameter int STABLE_SAMPLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  input  logic tick_i,
  output logic state_o,
  output logic evt_o
);

  localparam int CNT_W = $clog2(STABLE_SAMPLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_SAMPLES - 1);

  logic             sync1_q, sync2_q;
  logic             state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Bring the raw asynchronous input into the clock domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

  // On a tick, count differing samples; flip the level after enough in a row.
  always_comb begin
    cnt_d   = cnt_q;
    state_d = state_q;
    evt_o   = 1'b0;
    if (tick_i) begin
      if (sync2_q != state_q) begin
        if (cnt_q == CNT_LAST) begin
          state_d = ~state_q;
          cnt_d   = '0;
          evt_o   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else begin
        cnt_d = '0;
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/button_event_arbiter.sv
// Multi-channel button front end: shared sample prescaler, per-channel
// debouncers, per-channel pending slots and a round-robin event serializer.
//
// Event port handshake: evt_valid is raised with evt_ch/evt_press; while
// evt_valid is high and evt_ready low, all three hold steady. An event is
// consumed on a rising clk edge where evt_valid && evt_ready.
module button_event_arbiter
  import button_evt_pkg::*;
#(
  parameter int CLK_FREQUENCY  = 100_000_000,
  parameter int SAMPLE_US      = 1_000,
  parameter int STABLE_SAMPLES = 4,
  parameter int NUM_CH         = 5,
  localparam int CH_W          = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] btn_in,
  output logic [NUM_CH-1:0] btn_state,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [CH_W-1:0]   evt_ch,
  output logic              evt_press,
  output logic              evt_ovr,
  input  logic              ovr_clr
);

  localparam int TICK_CYCLES = tick_cycles(CLK_FREQUENCY, SAMPLE_US);
  localparam int TC_W        = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  logic [TC_W-1:0]   pre_q, pre_d;
  logic              tick;
  logic [NUM_CH-1:0] ch_evt;
  logic [NUM_CH-1:0] pending_q, pending_d;
  logic [NUM_CH-1:0] dir_q, dir_d;
  logic [NUM_CH-1:0] grant;
  logic              ovr_q, ovr_d, ovr_set;
  logic              evt_valid_q, evt_valid_d;
  logic [CH_W-1:0]   evt_ch_q, evt_ch_d;
  logic              evt_press_q, evt_press_d;
  logic [CH_W-1:0]   last_grant_q, last_grant_d;
  logic              load, found;
  logic [CH_W-1:0]   pick, probe;
  int                idx;

  // Prescaler wraps every TICK_CYCLES clocks; tick marks the last count.
  assign tick = (pre_q == TC_W'(TICK_CYCLES - 1));
  always_comb pre_d = tick ? '0 : pre_q + TC_W'(1);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    button_db_channel #(
      .STABLE_SAMPLES(STABLE_SAMPLES)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .btn_i  (btn_in[g]),
      .tick_i (tick),
      .state_o(btn_state[g]),
      .evt_o  (ch_evt[g])
    );
  end

  // Round-robin search starting just after the last granted channel.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    probe = '0;
    for (int off = 1; off <= NUM_CH; off++) begin
      idx   = (int'(last_grant_q) + off) % NUM_CH;
      probe = CH_W'(idx);
      if (!found && pending_q[probe]) begin
        found = 1'b1;
        pick  = probe;
      end
    end
  end

  assign load  = !evt_valid_q || evt_ready;
  assign grant = (load && found) ? (NUM_CH'(1) << pick) : '0;

  // Pending slots: grant clears first, a new event re-arms with the new level.
  always_comb begin
    pending_d = pending_q & ~grant;
    dir_d     = dir_q;
    ovr_set   = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_evt[c]) begin
        if (pending_d[c]) ovr_set = 1'b1;
        pending_d[c] = 1'b1;
        dir_d[c]     = ~btn_state[c];
      end
    end
  end

  // Output register reloads whenever it is empty or being consumed.
  always_comb begin
    evt_valid_d  = evt_valid_q;
    evt_ch_d     = evt_ch_q;
    evt_press_d  = evt_press_q;
    last_grant_d = last_grant_q;
    if (load) begin
      evt_valid_d = found;
      if (found) begin
        evt_ch_d     = pick;
        evt_press_d  = dir_q[pick];
        last_grant_d = pick;
      end
    end
  end

  // Sticky overrun flag; a fresh overrun beats a simultaneous clear.
  assign ovr_d = ovr_set | (ovr_q & ~ovr_clr);

  // All arbiter state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q        <= '0;
      pending_q    <= '0;
      dir_q        <= '0;
      ovr_q        <= 1'b0;
      evt_valid_q  <= 1'b0;
      evt_ch_q     <= '0;
      evt_press_q  <= 1'b0;
      last_grant_q <= CH_W'(NUM_CH - 1);
    end else begin
      pre_q        <= pre_d;
      pending_q    <= pending_d;
      dir_q        <= dir_d;
      ovr_q        <= ovr_d;
      evt_valid_q  <= evt_valid_d;
      evt_ch_q     <= evt_ch_d;
      evt_press_q  <= evt_press_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_ch    = evt_ch_q;
  assign evt_press = evt_press_q;
  assign evt_ovr   = ovr_q;

endmodule
